// File: rtl/lane_mask_serializer_pkg.sv
// Shared widths and FSM encoding for the lane mask serializer.
package lane_mask_serializer_pkg;

  localparam int DEF_NUM_LANE = 32;
  localparam int DEF_LANE_WID = 5;
  localparam int DEF_CNT_WID  = 6;
  localparam int DEF_TAG_WID  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/lane_mask_serializer_first_one.sv
// Lowest-set-bit finder: returns the lane index and a one-hot mask of that bit.
module lane_first_one #(
  parameter int NUM_LANE = 32,
  parameter int LANE_WID = 5
) (
  input  logic [NUM_LANE-1:0] mask_i,
  output logic [LANE_WID-1:0] idx_o,
  output logic [NUM_LANE-1:0] clr_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign clr_o = mask_i & (~mask_i + NUM_LANE'(1));

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_LANE - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = LANE_WID'(i);
    end
  end

endmodule

// File: rtl/pop_count.sv
// Population-count cell: number of set bits in a DATA_LEN-wide word.
module pop_count #(
  parameter int DATA_LEN = 32,
  parameter int DATA_WID = 6
) (
  input  logic [DATA_LEN-1:0] data_i,
  output logic [DATA_WID-1:0] cnt_o
);

  always_comb begin
    // NOTE: assigning a default first means every path drives cnt_o, so no latch is inferred.
    cnt_o = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      cnt_o = cnt_o + DATA_WID'(data_i[i]);
    end
  end

endmodule

// File: rtl/lane_mask_serializer.sv
// Serializes a warp request into one beat per active lane, lowest lane first,
// and reports a tagged done pulse when each request retires.
module lane_mask_serializer
  import lane_mask_serializer_pkg::*;
#(
  parameter int NUM_LANE = DEF_NUM_LANE,
  parameter int LANE_WID = DEF_LANE_WID,
  parameter int CNT_WID  = DEF_CNT_WID,
  parameter int TAG_WID  = DEF_TAG_WID
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NUM_LANE-1:0] in_mask_i,
  input  logic [TAG_WID-1:0]  in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LANE_WID-1:0] out_lane_o,
  output logic [CNT_WID-1:0]  out_beat_o,
  output logic                out_last_o,
  output logic [TAG_WID-1:0]  out_tag_o,
  output logic [CNT_WID-1:0]  lane_cnt_o,
  output logic                done_o,
  output logic [TAG_WID-1:0]  done_tag_o,
  output logic                busy_o
);

  state_e              state_q, state_d;
  logic [NUM_LANE-1:0] rem_mask_q, rem_mask_d;
  logic [TAG_WID-1:0]  tag_q, tag_d;
  logic [CNT_WID-1:0]  beat_q, beat_d;
  logic [CNT_WID-1:0]  cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [TAG_WID-1:0]  done_tag_q, done_tag_d;
  logic                pend_q, pend_d;
  logic [TAG_WID-1:0]  pend_tag_q, pend_tag_d;

  logic [CNT_WID-1:0]  in_cnt;
  logic [NUM_LANE-1:0] lane_clr;
  logic                issue, xfer, last_xfer, accept, mask_zero;

  pop_count #(
    .DATA_LEN (NUM_LANE),
    .DATA_WID (CNT_WID)
  ) u_pop_count (
    .data_i (in_mask_i),
    .cnt_o  (in_cnt)
  );

  lane_first_one #(
    .NUM_LANE (NUM_LANE),
    .LANE_WID (LANE_WID)
  ) u_first_one (
    .mask_i (rem_mask_q),
    .idx_o  (out_lane_o),
    .clr_o  (lane_clr)
  );

  assign issue       = (state_q == ST_ISSUE);
  assign out_valid_o = issue;
  assign busy_o      = issue;
  assign out_last_o  = issue && (beat_q == cnt_q - CNT_WID'(1));
  assign out_beat_o  = beat_q;
  assign out_tag_o   = tag_q;
  assign lane_cnt_o  = issue ? cnt_q : '0;
  assign done_o      = done_q;
  assign done_tag_o  = done_tag_q;

  assign xfer      = issue & out_ready_i;
  assign last_xfer = xfer & out_last_o;
  // A parked zero-mask done blocks new requests until it has been reported.
  assign in_ready_o = (~issue | last_xfer) & ~pend_q;
  assign accept     = in_valid_i & in_ready_o;
  assign mask_zero  = (in_mask_i == '0);

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    done_tag_d = done_tag_q;
    pend_d     = pend_q;
    pend_tag_d = pend_tag_q;

    if (xfer) begin
      rem_mask_d = rem_mask_q & ~lane_clr;
      beat_d     = beat_q + CNT_WID'(1);
    end

    if (last_xfer) begin
      done_d     = 1'b1;
      done_tag_d = tag_q;
      state_d    = ST_IDLE;
    end

    if (pend_q) begin
      done_d     = 1'b1;
      done_tag_d = pend_tag_q;
      pend_d     = 1'b0;
    end

    if (accept) begin
      if (!mask_zero) begin
        state_d    = ST_ISSUE;
        rem_mask_d = in_mask_i;
        tag_d      = in_tag_i;
        cnt_d      = in_cnt;
        beat_d     = '0;
      end else if (last_xfer) begin
        // The retiring request owns this done slot; report the empty one next.
        pend_d     = 1'b1;
        pend_tag_d = in_tag_i;
      end else begin
        done_d     = 1'b1;
        done_tag_d = in_tag_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
      tag_q      <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      done_tag_q <= '0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      tag_q      <= tag_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      done_tag_q <= done_tag_d;
      pend_q     <= pend_d;
      pend_tag_q <= pend_tag_d;
    end
  end

endmodule
